mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  MEM-stage load/store controller. Runs one access at a time over the SRAM-like data bus
//  (req/addr_ok/data_ok). It checks alignment and drives byte strobes. Store data is
//  replicated across lanes. Load data is lane-extracted and sign/zero-extended into a
//  registered response. Generalises the 32-bit load decoder to DATA_W=32/64, and adds stores,
//  address exceptions, a bus handshake and pipeline flush.
// PARAMETERS
//  DATA_W  32  datapath width; legal values 32 or 64; LANES=DATA_W/8, LB_W=log2(LANES)
//  ADDR_W  32  address width
// PORTS
//  clk           in   1        clock
//  rst           in   1        asynchronous, active-high reset
//  req_valid     in   1        MEM stage presents an access
//  req_op        in   4        {store, unsigned, size[1:0]}; size 0=B 1=H 2=W 3=D
//  req_addr      in   ADDR_W   virtual=physical address
//  req_wdata     in   DATA_W   store data, right-aligned
//  req_ready     out  1        controller idle, may accept
//  flush         in   1        pipeline flush (exception/eret)
//  resp_valid    out  1        1-cycle completion pulse
//  resp_rdata    out  DATA_W   extended load result (0 for stores/exceptions)
//  excp_adel     out  1        misaligned load, valid with resp_valid
//  excp_ades     out  1        misaligned store, valid with resp_valid
//  bad_vaddr     out  ADDR_W   faulting address, valid with excp_*
//  data_req      out  1        bus request
//  data_wr       out  1        1=write
//  data_size     out  2        access size, same encoding as req_op[1:0]
//  data_addr     out  ADDR_W   bus address (unaligned low bits passed through)
//  data_wstrb    out  LANES    byte strobes (0 on reads)
//  data_wdata    out  DATA_W   lane-replicated store data
//  data_addr_ok  in   1        address accepted
//  data_data_ok  in   1        read data / write complete
//  data_rdata    in   DATA_W   read data
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 except req_ready=1.
//  States: IDLE, ADDR, DATA. req_ready=1 only in IDLE.
//  IDLE, accept when req_valid&&!flush:
//   - Legality: size 3 with DATA_W=32 and op 11xx are illegal. An illegal op makes no bus
//     access; next cycle resp_valid=1 with rdata=0 and no excp; state stays IDLE.
//   - Alignment: misaligned = H&addr[0], W&|addr[1:0], D&|addr[2:0]. No bus access; next cycle
//     resp_valid=1, excp_adel (load) or excp_ades (store)=1, bad_vaddr=addr, rdata=0.
//   - Otherwise latch op/addr. Store: wdata=replicated unit, wstrb=((1<<bytes)-1)<<addr[LB_W-1:0].
//     Go to ADDR.
//  ADDR: data_req=1, bus outputs held stable.
//   - data_addr_ok=1 -> DATA.
//   - flush before addr_ok -> IDLE, request withdrawn, no response.
//   - flush in the same cycle as addr_ok -> DATA with discard=1.
//  DATA: data_req=0; data_data_ok is ignored in every other state.
//   - On data_data_ok -> IDLE. If discard=0, next cycle resp_valid=1 and resp_rdata=extract.
//   - flush in DATA sets discard; the transfer still completes on the bus.
//  Extract (loads): unit at data_rdata[8*addr[LB_W-1:0] +: 8*bytes]. Sign-extend to DATA_W,
//   or zero-extend if op[2]. Stores: resp_rdata=0.
//  Minimum latency, accept to resp_valid: 3 cycles (accept, addr_ok, data_ok, resp).
//  discard clears on entry to IDLE. resp_valid never asserts twice per access.
//  Mid-operation rst returns to IDLE at once; outputs go to reset values.
// TESTING
//  1. DATA_W=32, LB addr 0x..03, rdata=0x80FF_0000 -> resp_rdata=0xFFFF_FF80, 3 cycles after accept.
//  2. SH addr 0x..02, wdata=0x1234 -> data_wstrb=4'b1100, data_wdata=0x1234_1234, data_wr=1; resp_rdata=0.
//  3. LW addr 0x..02 -> no data_req; next cycle resp_valid=1, excp_adel=1, bad_vaddr=0x..02.
//  4. flush in ADDR with addr_ok held 0 -> data_req drops next cycle, no resp_valid, req_ready=1.
//  5. flush in DATA, data_ok 4 cycles later -> no resp_valid; a following LHU accepts and completes normally.
//  6. DATA_W=64, LWU addr 0x..04, rdata upper word 0x8000_0001 -> resp_rdata=0x0000_0000_8000_0001; LD addr 0x..04 -> excp_adel.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// Data-side SRAM-like bus between the MEM-stage access controller and memory.
//
// Handshake: the master raises data_req and holds data_wr/size/addr/wstrb/wdata
// stable until the slave returns data_addr_ok in the same cycle (address phase
// done). The access then completes on the single-cycle data_data_ok pulse, and
// data_rdata is valid with it for reads.
//
// Modports:
//   master : drives the request fields, receives addr_ok/data_ok/rdata
//   slave  : the memory side
interface mem_access_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  localparam int LANES = DATA_W / 8;

  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [ADDR_W-1:0] data_addr;
  logic [LANES-1:0]  data_wstrb;
  logic [DATA_W-1:0] data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [DATA_W-1:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store controller. One access in flight at a time.
// Checks legality and alignment, drives lane-replicated store data and byte
// strobes onto the bus, and returns a registered, sign/zero-extended load result
// as a single-cycle resp_valid pulse.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   req_valid/op/addr/    access request from the MEM stage; accepted in a cycle
//   req_wdata, req_ready  where req_valid && req_ready && !flush
//   flush                 kills the in-flight access (no response)
//   resp_valid/rdata      1-cycle completion pulse with extended load data
//   excp_adel/ades,       misaligned load/store, valid with resp_valid
//   bad_vaddr
//   bus                   SRAM-like data bus (master side)
//   state_dbg             current FSM state (0=IDLE 1=ADDR 2=DATA)
module mem_access_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [3:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  input  logic              flush,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              excp_adel,
  output logic              excp_ades,
  output logic [ADDR_W-1:0] bad_vaddr,
  mem_access_ctrl_if.master bus,
  output logic [1:0]        state_dbg
);
  localparam int LANES = DATA_W / 8;
  localparam int LB_W  = $clog2(LANES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LANES-1:0]  wstrb_q, wstrb_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              discard_q, discard_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic              excp_adel_q, excp_adel_d;
  logic              excp_ades_q, excp_ades_d;
  logic [ADDR_W-1:0] bad_vaddr_q, bad_vaddr_d;

  // Request decode
  logic              req_illegal;
  logic              req_misaligned;
  logic [3:0]        req_nbytes;
  logic [LANES-1:0]  req_strb;
  logic [DATA_W-1:0] req_rep;

  // Load extraction
  logic [DATA_W-1:0] unit_sh;
  logic [DATA_W-1:0] unit_mask;
  logic [6:0]        unit_bits;
  logic              unit_sign;
  logic [DATA_W-1:0] load_ext;

  always_comb begin
    req_illegal    = (req_op[3:2] == 2'b11) || ((req_op[1:0] == 2'd3) && (DATA_W == 32));
    req_misaligned = 1'b0;
    case (req_op[1:0])
      2'd1:    req_misaligned = req_addr[0];
      2'd2:    req_misaligned = |req_addr[1:0];
      2'd3:    req_misaligned = |req_addr[2:0];
      default: req_misaligned = 1'b0;
    endcase
    req_nbytes = 4'd1 << req_op[1:0];
    // Contiguous run of req_nbytes ones, moved up to the addressed lane.
    req_strb   = (~({LANES{1'b1}} << req_nbytes)) << req_addr[LB_W-1:0];
    req_rep    = req_wdata;
    case (req_op[1:0])
      2'd0:    req_rep = {LANES{req_wdata[7:0]}};
      2'd1:    req_rep = {(LANES/2){req_wdata[15:0]}};
      2'd2:    req_rep = {(LANES/4){req_wdata[31:0]}};
      default: req_rep = req_wdata;
    endcase
  end

  always_comb begin
    unit_sh   = bus.data_rdata >> {addr_q[LB_W-1:0], 3'b000};
    unit_bits = 7'd8 << op_q[1:0];
    // A full-width unit shifts every one out, leaving an all-ones mask.
    unit_mask = ~({DATA_W{1'b1}} << unit_bits);
    case (op_q[1:0])
      2'd0:    unit_sign = unit_sh[7];
      2'd1:    unit_sign = unit_sh[15];
      2'd2:    unit_sign = unit_sh[31];
      default: unit_sign = unit_sh[DATA_W-1];
    endcase
    load_ext = (unit_sh & unit_mask) | ((unit_sign && !op_q[2]) ? ~unit_mask : '0);
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    addr_d       = addr_q;
    wstrb_d      = wstrb_q;
    wdata_d      = wdata_q;
    discard_d    = discard_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = '0;
    excp_adel_d  = 1'b0;
    excp_ades_d  = 1'b0;
    bad_vaddr_d  = '0;
    case (state_q)
      S_IDLE: begin
        discard_d = 1'b0;
        if (req_valid && !flush) begin
          if (req_illegal) begin
            resp_valid_d = 1'b1;
          end else if (req_misaligned) begin
            resp_valid_d = 1'b1;
            excp_adel_d  = !req_op[3];
            excp_ades_d  = req_op[3];
            bad_vaddr_d  = req_addr;
          end else begin
            op_d    = req_op;
            addr_d  = req_addr;
            wstrb_d = req_op[3] ? req_strb : '0;
            wdata_d = req_rep;
            state_d = S_ADDR;
          end
        end
      end
      S_ADDR: begin
        if (bus.data_addr_ok) begin
          // Once the address is taken the bus transfer must finish; a flush
          // here only suppresses the response.
          state_d = S_DATA;
          if (flush) discard_d = 1'b1;
        end else if (flush) begin
          state_d = S_IDLE;
        end
      end
      S_DATA: begin
        if (flush) discard_d = 1'b1;
        if (bus.data_data_ok) begin
          state_d   = S_IDLE;
          discard_d = 1'b0;
          if (!discard_q && !flush) begin
            resp_valid_d = 1'b1;
            resp_rdata_d = op_q[3] ? '0 : load_ext;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      addr_q       <= '0;
      wstrb_q      <= '0;
      wdata_q      <= '0;
      discard_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      excp_adel_q  <= 1'b0;
      excp_ades_q  <= 1'b0;
      bad_vaddr_q  <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      wstrb_q      <= wstrb_d;
      wdata_q      <= wdata_d;
      discard_q    <= discard_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      excp_adel_q  <= excp_adel_d;
      excp_ades_q  <= excp_ades_d;
      bad_vaddr_q  <= bad_vaddr_d;
    end
  end

  logic busy;
  assign busy = (state_q != S_IDLE);

  assign req_ready      = (state_q == S_IDLE);
  assign resp_valid     = resp_valid_q;
  assign resp_rdata     = resp_rdata_q;
  assign excp_adel      = excp_adel_q;
  assign excp_ades      = excp_ades_q;
  assign bad_vaddr      = bad_vaddr_q;
  assign state_dbg      = state_q;

  assign bus.data_req   = (state_q == S_ADDR);
  assign bus.data_wr    = busy && op_q[3];
  assign bus.data_size  = busy ? op_q[1:0] : 2'd0;
  assign bus.data_addr  = busy ? addr_q : '0;
  assign bus.data_wstrb = busy ? wstrb_q : '0;
  assign bus.data_wdata = busy ? wdata_q : '0;
endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;
  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- stimulus signals ----------------
  logic        sel = 1'b0;  // 0: drive/observe 32-bit DUT, 1: 64-bit DUT
  logic        req_valid = 1'b0;
  logic        flush = 1'b0;
  logic [3:0]  req_op = '0;
  logic [31:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        mem_addr_ok = 1'b0;
  logic        mem_data_ok = 1'b0;
  logic [63:0] mem_rdata = '0;

  mem_access_ctrl_if #(.DATA_W(32), .ADDR_W(32)) bus32 ();
  mem_access_ctrl_if #(.DATA_W(64), .ADDR_W(32)) bus64 ();

  assign bus32.data_addr_ok = mem_addr_ok;
  assign bus32.data_data_ok = mem_data_ok;
  assign bus32.data_rdata   = mem_rdata[31:0];
  assign bus64.data_addr_ok = mem_addr_ok;
  assign bus64.data_data_ok = mem_data_ok;
  assign bus64.data_rdata   = mem_rdata;

  logic        r32_ready, r32_valid, r32_adel, r32_ades;
  logic [31:0] r32_rdata, r32_bad;
  logic [1:0]  r32_state;
  logic        r64_ready, r64_valid, r64_adel, r64_ades;
  logic [63:0] r64_rdata;
  logic [31:0] r64_bad;
  logic [1:0]  r64_state;

  mem_access_ctrl #(.DATA_W(32), .ADDR_W(32)) u_dut32 (
    .clk(clk), .rst(rst), .req_valid(req_valid && !sel), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata[31:0]), .req_ready(r32_ready),
    .flush(flush), .resp_valid(r32_valid), .resp_rdata(r32_rdata),
    .excp_adel(r32_adel), .excp_ades(r32_ades), .bad_vaddr(r32_bad),
    .bus(bus32.master), .state_dbg(r32_state)
  );

  mem_access_ctrl #(.DATA_W(64), .ADDR_W(32)) u_dut64 (
    .clk(clk), .rst(rst), .req_valid(req_valid && sel), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(r64_ready),
    .flush(flush), .resp_valid(r64_valid), .resp_rdata(r64_rdata),
    .excp_adel(r64_adel), .excp_ades(r64_ades), .bad_vaddr(r64_bad),
    .bus(bus64.master), .state_dbg(r64_state)
  );

  // Selected-DUT view
  logic        s_ready, s_valid, s_adel, s_ades, s_dreq, s_dwr;
  logic [63:0] s_rdata, s_dwdata;
  logic [31:0] s_bad, s_daddr;
  logic [1:0]  s_state, s_dsize;
  logic [7:0]  s_dstrb;

  assign s_ready  = sel ? r64_ready : r32_ready;
  assign s_valid  = sel ? r64_valid : r32_valid;
  assign s_adel   = sel ? r64_adel  : r32_adel;
  assign s_ades   = sel ? r64_ades  : r32_ades;
  assign s_rdata  = sel ? r64_rdata : {32'h0, r32_rdata};
  assign s_bad    = sel ? r64_bad   : r32_bad;
  assign s_state  = sel ? r64_state : r32_state;
  assign s_dreq   = sel ? bus64.data_req   : bus32.data_req;
  assign s_dwr    = sel ? bus64.data_wr    : bus32.data_wr;
  assign s_dsize  = sel ? bus64.data_size  : bus32.data_size;
  assign s_daddr  = sel ? bus64.data_addr  : bus32.data_addr;
  assign s_dstrb  = sel ? bus64.data_wstrb : {4'h0, bus32.data_wstrb};
  assign s_dwdata = sel ? bus64.data_wdata : {32'h0, bus32.data_wdata};

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // ---------------- scoreboard ----------------
  // {adel, ades, bad_vaddr[31:0], rdata[63:0]}
  logic [97:0] exp_q[$];
  int resp_cyc = -1;

  always @(negedge clk) begin
    if (!rst && s_valid) begin
      resp_cyc = cyc;
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", 128'(1), 128'(0));
      end else begin
        logic [97:0] e;
        e = exp_q.pop_front();
        chk("resp", 128'({s_adel, s_ades, s_bad, s_rdata}), 128'(e));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_req(input logic [3:0] op, input logic [31:0] addr, input logic [63:0] wdata);
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  // Full access: model the expected bus fields and response, then play the
  // memory side with the given address/data-phase wait cycles.
  task automatic do_access(input logic [3:0] op, input logic [31:0] addr, input logic [63:0] wdata,
                           input logic [63:0] rdata, input int alat, input int dlat);
    int nbytes, lanes, lane, acc_cyc;
    logic illegal, mis;
    logic [63:0] v, wrep;
    logic [7:0] strb;
    nbytes  = 1 << op[1:0];
    lanes   = sel ? 8 : 4;
    lane    = sel ? int'(addr[2:0]) : int'(addr[1:0]);
    illegal = (op[3:2] == 2'b11) || (op[1:0] == 2'd3 && !sel);
    mis     = !illegal && ((int'(addr[2:0]) % nbytes) != 0);
    v = '0; strb = '0; wrep = '0;
    if (!illegal && !mis) begin
      for (int i = 0; i < nbytes; i++) begin
        v[8*i +: 8] = rdata[8*(lane+i) +: 8];
        strb[lane+i] = op[3];
      end
      if (!op[2] && v[8*nbytes-1])
        for (int b = 8*nbytes; b < 8*lanes; b++) v[b] = 1'b1;
      if (op[3]) v = '0;
    end
    for (int j = 0; j < lanes; j++) wrep[8*j +: 8] = wdata[8*(j % nbytes) +: 8];
    exp_q.push_back({mis && !op[3], mis && op[3], mis ? addr : 32'h0, v});
    resp_cyc = -1;
    chk("req_ready", 128'(s_ready), 128'(1));
    acc_cyc = cyc;
    start_req(op, addr, wdata);
    if (illegal || mis) begin
      chk("no_bus_req", 128'(s_dreq), 128'(0));
      tick();
      tick();
      chk("latency_excp", 128'(resp_cyc - acc_cyc), 128'(1));
    end else begin
      chk("data_req", 128'(s_dreq), 128'(1));
      chk("data_wr", 128'(s_dwr), 128'(op[3]));
      chk("data_size", 128'(s_dsize), 128'(op[1:0]));
      chk("data_addr", 128'(s_daddr), 128'(addr));
      chk("data_wstrb", 128'(s_dstrb), 128'(strb));
      if (op[3]) chk("data_wdata", 128'(s_dwdata), 128'(wrep));
      repeat (alat) begin
        tick();
        chk("req_held", 128'(s_dreq), 128'(1));
      end
      mem_addr_ok = 1'b1;
      tick();
      mem_addr_ok = 1'b0;
      chk("req_dropped", 128'(s_dreq), 128'(0));
      repeat (dlat) tick();
      mem_data_ok = 1'b1;
      mem_rdata   = rdata;
      tick();
      mem_data_ok = 1'b0;
      mem_rdata   = {$urandom(), $urandom()};
      tick();
      chk("latency", 128'(resp_cyc - acc_cyc), 128'(3 + alat + dlat));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();

    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #1;
      chk("rst_ready", 128'(s_ready), 128'(1));
      chk("rst_resp_valid", 128'(s_valid), 128'(0));
      chk("rst_data_req", 128'(s_dreq), 128'(0));
      chk("rst_wstrb", 128'(s_dstrb), 128'(0));
      chk("rst_state", 128'(s_state), 128'(0));
    end

    sel = 1'b0;
    do_access(4'b0000, 32'h0000_1003, 64'h0, 64'h80FF_0000, 0, 0);       // LB sign
    do_access(4'b1001, 32'h0000_2002, 64'h1234, 64'hDEAD_BEEF, 1, 0);    // SH
    do_access(4'b0010, 32'h0000_3002, 64'h0, 64'h0, 0, 0);               // LW misaligned
    do_access(4'b1010, 32'h0000_3001, 64'h55, 64'h0, 0, 0);              // SW misaligned
    do_access(4'b1110, 32'h0000_0100, 64'h0, 64'h0, 0, 0);               // illegal op
    do_access(4'b0011, 32'h0000_0008, 64'h0, 64'h0, 0, 0);               // LD on 32-bit

    // Flush while address phase is stalled: request withdrawn, no response.
    start_req(4'b0010, 32'h0000_4000, 64'h0);
    chk("f4_req", 128'(s_dreq), 128'(1));
    tick();
    chk("f4_req_held", 128'(s_dreq), 128'(1));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("f4_req_drop", 128'(s_dreq), 128'(0));
    chk("f4_ready", 128'(s_ready), 128'(1));
    repeat (3) tick();

    // Flush in data phase: transfer completes, response suppressed.
    start_req(4'b0010, 32'h0000_5000, 64'h0);
    mem_addr_ok = 1'b1;
    tick();
    mem_addr_ok = 1'b0;
    chk("f5_state_data", 128'(s_state), 128'(2));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (3) tick();
    chk("f5_still_busy", 128'(s_ready), 128'(0));
    mem_data_ok = 1'b1;
    mem_rdata   = 64'h1111_2222;
    tick();
    mem_data_ok = 1'b0;
    chk("f5_ready", 128'(s_ready), 128'(1));
    repeat (2) tick();
    do_access(4'b0101, 32'h0000_6002, 64'h0, 64'h8001_0000, 0, 1);       // LHU after flush

    sel = 1'b1;
    do_access(4'b0110, 32'h0000_7004, 64'h0, 64'h8000_0001_0000_0000, 0, 0); // LWU
    do_access(4'b0011, 32'h0000_7004, 64'h0, 64'h0, 0, 0);                    // LD misaligned
    do_access(4'b0011, 32'h0000_7008, 64'h0, 64'h8123_4567_89AB_CDEF, 2, 2);  // LD
    do_access(4'b1000, 32'h0000_7005, 64'hA5, 64'h0, 0, 0);                   // SB
    do_access(4'b0001, 32'h0000_7006, 64'h0, 64'hFEDC_0000_0000_0000, 0, 0);  // LH sign

    for (int k = 0; k < 40; k++) begin
      logic [31:0] a;
      sel = 1'($urandom_range(0, 1));
      a = $urandom();
      if ($urandom_range(0, 2) != 0) a = a & ~32'h7 | 32'($urandom_range(0, 1) * 4);
      do_access(4'($urandom_range(0, 15)), a, {$urandom(), $urandom()}, {$urandom(), $urandom()},
                $urandom_range(0, 2), $urandom_range(0, 2));
    end

    // Reset in the middle of an access returns to idle immediately.
    sel = 1'b0;
    start_req(4'b0010, 32'h0000_8000, 64'h0);
    chk("mr_req", 128'(s_dreq), 128'(1));
    rst = 1'b1;
    #1;
    chk("mr_ready", 128'(s_ready), 128'(1));
    chk("mr_data_req", 128'(s_dreq), 128'(0));
    chk("mr_state", 128'(s_state), 128'(0));
    tick();
    rst = 1'b0;
    repeat (2) tick();
    chk("mr_resp_valid", 128'(s_valid), 128'(0));

    chk("exp_q_empty", 128'(exp_q.size()), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
